// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB.
// The EX slot holds decoded operands. Forwarding is resolved combinationally
// against the registered source indices, so the alu and branch_alu always see
// the newest value of each source register.
module id_ex_operand_stage #(
  parameter int WORD_W = 16,
  parameter int REG_W  = 2,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [WORD_W-1:0] id_rs_data,
  input  logic [WORD_W-1:0] id_rt_data,
  input  logic [WORD_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic [FUNC_W-1:0] id_func_code,
  input  logic [5:0]        id_br_op,
  input  logic              id_reg_write,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [WORD_W-1:0] exmem_value,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [WORD_W-1:0] memwb_value,
  output logic              ex_valid,
  output logic [WORD_W-1:0] ex_alu_a,
  output logic [WORD_W-1:0] ex_alu_b,
  output logic [WORD_W-1:0] ex_br_a,
  output logic [WORD_W-1:0] ex_br_b,
  output logic [FUNC_W-1:0] ex_func_code,
  output logic [5:0]        ex_br_op,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_reg_write,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b
);

  localparam logic [5:0] BR_NONE  = 6'h3F;
  localparam logic [1:0] SEL_HELD = 2'd0;
  localparam logic [1:0] SEL_EXMEM = 2'd1;
  localparam logic [1:0] SEL_MEMWB = 2'd2;

  logic              valid_q,     valid_d;
  logic [REG_W-1:0]  rs_q,        rs_d;
  logic [REG_W-1:0]  rt_q,        rt_d;
  logic [REG_W-1:0]  rd_q,        rd_d;
  logic [WORD_W-1:0] rs_data_q,   rs_data_d;
  logic [WORD_W-1:0] rt_data_q,   rt_data_d;
  logic [WORD_W-1:0] imm_q,       imm_d;
  logic              alu_src_q,   alu_src_d;
  logic [FUNC_W-1:0] func_q,      func_d;
  logic [5:0]        br_op_q,     br_op_d;
  logic              reg_write_q, reg_write_d;

  logic [WORD_W-1:0] rs_fwd;
  logic [WORD_W-1:0] rt_fwd;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;

  // Forwarding select: EX/MEM is newer than MEM/WB, so it wins when both match.
  always_comb begin
    sel_a  = SEL_HELD;
    rs_fwd = rs_data_q;
    if (exmem_reg_write && (exmem_rd == rs_q)) begin
      sel_a  = SEL_EXMEM;
      rs_fwd = exmem_value;
    end else if (memwb_reg_write && (memwb_rd == rs_q)) begin
      sel_a  = SEL_MEMWB;
      rs_fwd = memwb_value;
    end

    sel_b  = SEL_HELD;
    rt_fwd = rt_data_q;
    if (exmem_reg_write && (exmem_rd == rt_q)) begin
      sel_b  = SEL_EXMEM;
      rt_fwd = exmem_value;
    end else if (memwb_reg_write && (memwb_rd == rt_q)) begin
      sel_b  = SEL_MEMWB;
      rt_fwd = memwb_value;
    end
  end

  // Next EX slot contents: flush beats stall beats load.
  always_comb begin
    valid_d     = valid_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    func_d      = func_q;
    br_op_d     = br_op_q;
    reg_write_d = reg_write_q;

    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      br_op_d     = BR_NONE;
    end else if (stall) begin
      // Latch the forwarded operands so a producer that retires out of
      // MEM/WB while we are stalled is not lost.
      rs_data_d = rs_fwd;
      rt_data_d = rt_fwd;
    end else begin
      valid_d     = id_valid;
      rs_d        = id_rs;
      rt_d        = id_rt;
      rd_d        = id_rd;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm;
      alu_src_d   = id_alu_src;
      func_d      = id_func_code;
      br_op_d     = id_valid ? id_br_op : BR_NONE;
      reg_write_d = id_reg_write & id_valid;
    end
  end

  // EX slot register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      func_q      <= '0;
      br_op_q     <= BR_NONE;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      func_q      <= func_d;
      br_op_q     <= br_op_d;
      reg_write_q <= reg_write_d;
    end
  end

  // Operand muxing and bubble gating toward the EX units.
  always_comb begin
    ex_valid     = valid_q;
    ex_alu_a     = rs_fwd;
    ex_alu_b     = alu_src_q ? imm_q : rt_fwd;
    ex_br_a      = rs_fwd;
    ex_br_b      = rt_fwd;
    ex_func_code = func_q;
    ex_rd        = rd_q;
    ex_reg_write = reg_write_q & valid_q;
    ex_br_op     = valid_q ? br_op_q : BR_NONE;
    ex_fwd_a     = sel_a;
    ex_fwd_b     = sel_b;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed hazard scenarios plus randomized
// traffic checked against a behavioural model of the EX slot.
module tb_id_ex_operand_stage;

  localparam int WORD_W = 16;
  localparam int REG_W  = 2;
  localparam int FUNC_W = 4;

  logic              clk;
  logic              reset_n;
  logic              stall, flush;
  logic              id_valid;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd;
  logic [WORD_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic              id_alu_src;
  logic [FUNC_W-1:0] id_func_code;
  logic [5:0]        id_br_op;
  logic              id_reg_write;
  logic              exmem_reg_write;
  logic [REG_W-1:0]  exmem_rd;
  logic [WORD_W-1:0] exmem_value;
  logic              memwb_reg_write;
  logic [REG_W-1:0]  memwb_rd;
  logic [WORD_W-1:0] memwb_value;
  logic              ex_valid;
  logic [WORD_W-1:0] ex_alu_a, ex_alu_b, ex_br_a, ex_br_b;
  logic [FUNC_W-1:0] ex_func_code;
  logic [5:0]        ex_br_op;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write;
  logic [1:0]        ex_fwd_a, ex_fwd_b;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural view of the EX slot.
  logic              m_valid;
  logic [REG_W-1:0]  m_rs, m_rt, m_rd;
  logic [WORD_W-1:0] m_rsd, m_rtd, m_imm;
  logic              m_src;
  logic [FUNC_W-1:0] m_func;
  logic [5:0]        m_br;
  logic              m_rw;

  id_ex_operand_stage #(.WORD_W(WORD_W), .REG_W(REG_W), .FUNC_W(FUNC_W)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_func_code(id_func_code), .id_br_op(id_br_op),
    .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_value(exmem_value),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_value(memwb_value),
    .ex_valid(ex_valid), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_br_a(ex_br_a), .ex_br_b(ex_br_b), .ex_func_code(ex_func_code),
    .ex_br_op(ex_br_op), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Newest value of register r as seen from EX, given the value held in the slot.
  function automatic logic [WORD_W-1:0] newest(input logic [REG_W-1:0] r, input logic [WORD_W-1:0] held);
    if (exmem_reg_write && exmem_rd == r) return exmem_value;
    if (memwb_reg_write && memwb_rd == r) return memwb_value;
    return held;
  endfunction

  function automatic logic [1:0] source_of(input logic [REG_W-1:0] r);
    if (exmem_reg_write && exmem_rd == r) return 2'd1;
    if (memwb_reg_write && memwb_rd == r) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_rsd = '0; m_rtd = '0; m_imm = '0; m_src = 1'b0;
    m_func = '0; m_br = 6'h3F; m_rw = 1'b0;
  endtask

  task automatic model_edge();
    if (!reset_n) model_clear();
    else if (flush) m_valid = 1'b0;
    else if (stall) begin
      m_rsd = newest(m_rs, m_rsd);
      m_rtd = newest(m_rt, m_rtd);
    end else begin
      m_valid = id_valid; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      m_src = id_alu_src; m_func = id_func_code; m_br = id_br_op; m_rw = id_reg_write;
    end
  endtask

  task automatic check_model();
    logic [WORD_W-1:0] a, b;
    a = newest(m_rs, m_rsd);
    b = newest(m_rt, m_rtd);
    chk("valid", 32'(ex_valid), 32'(m_valid));
    chk("reg_write", 32'(ex_reg_write), 32'(m_valid && m_rw));
    chk("br_op", 32'(ex_br_op), m_valid ? 32'(m_br) : 32'h3F);
    if (m_valid) begin
      chk("alu_a", 32'(ex_alu_a), 32'(a));
      chk("alu_b", 32'(ex_alu_b), m_src ? 32'(m_imm) : 32'(b));
      chk("br_a", 32'(ex_br_a), 32'(a));
      chk("br_b", 32'(ex_br_b), 32'(b));
      chk("func", 32'(ex_func_code), 32'(m_func));
      chk("rd", 32'(ex_rd), 32'(m_rd));
      chk("fwd_a", 32'(ex_fwd_a), 32'(source_of(m_rs)));
      chk("fwd_b", 32'(ex_fwd_b), 32'(source_of(m_rt)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    stall = 0; flush = 0; id_valid = 0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_alu_src = 0; id_func_code = '0; id_br_op = 6'h3F; id_reg_write = 0;
    exmem_reg_write = 0; exmem_rd = '0; exmem_value = '0;
    memwb_reg_write = 0; memwb_rd = '0; memwb_value = '0;
  endtask

  task automatic load_instr(input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd,
                            input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                            input logic src, input logic [3:0] func, input logic [5:0] br,
                            input logic rw);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_src = src; id_func_code = func; id_br_op = br; id_reg_write = rw;
  endtask

  task automatic randomize_inputs();
    stall = ($urandom_range(0, 3) == 0);
    flush = ($urandom_range(0, 7) == 0);
    id_valid = ($urandom_range(0, 4) != 0);
    id_rs = 2'($urandom); id_rt = 2'($urandom); id_rd = 2'($urandom);
    id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 16'($urandom);
    id_alu_src = 1'($urandom); id_func_code = 4'($urandom_range(0, 9));
    id_br_op = 6'($urandom); id_reg_write = 1'($urandom);
    exmem_reg_write = 1'($urandom); exmem_rd = 2'($urandom); exmem_value = 16'($urandom);
    memwb_reg_write = 1'($urandom); memwb_rd = 2'($urandom); memwb_value = 16'($urandom);
  endtask

  // Assert reset mid-cycle and expect every output to clear before the next edge.
  task automatic do_reset();
    exmem_reg_write = 0;
    memwb_reg_write = 0;
    #2 reset_n = 0;
    #1;
    model_clear();
    chk("rst_valid", 32'(ex_valid), 32'h0);
    chk("rst_alu_a", 32'(ex_alu_a), 32'h0);
    chk("rst_alu_b", 32'(ex_alu_b), 32'h0);
    chk("rst_br_a", 32'(ex_br_a), 32'h0);
    chk("rst_br_b", 32'(ex_br_b), 32'h0);
    chk("rst_func", 32'(ex_func_code), 32'h0);
    chk("rst_br_op", 32'(ex_br_op), 32'h3F);
    chk("rst_rd", 32'(ex_rd), 32'h0);
    chk("rst_reg_write", 32'(ex_reg_write), 32'h0);
    chk("rst_fwd_a", 32'(ex_fwd_a), 32'h0);
    chk("rst_fwd_b", 32'(ex_fwd_b), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    reset_n = 1;
    set_idle();
    model_clear();
    @(negedge clk);
    do_reset();

    // Plain load with no hazards.
    set_idle();
    load_instr(2'd1, 2'd2, 2'd3, 16'h0005, 16'h0003, 16'h0000, 1'b0, 4'd1, 6'd1, 1'b1);
    #1 check_model();
    tick();
    set_idle();
    #1 check_model();
    chk("load_alu_a", 32'(ex_alu_a), 32'h0005);
    chk("load_alu_b", 32'(ex_alu_b), 32'h0003);
    chk("load_fwd_a", 32'(ex_fwd_a), 32'h0);
    chk("load_fwd_b", 32'(ex_fwd_b), 32'h0);
    chk("load_reg_write", 32'(ex_reg_write), 32'h1);
    tick();

    // Both later stages write rs: EX/MEM wins, then MEM/WB alone.
    load_instr(2'd1, 2'd0, 2'd2, 16'h0011, 16'h0022, 16'h0000, 1'b0, 4'd2, 6'h3F, 1'b1);
    tick();
    set_idle();
    exmem_reg_write = 1; exmem_rd = 2'd1; exmem_value = 16'h00AA;
    memwb_reg_write = 1; memwb_rd = 2'd1; memwb_value = 16'h00BB;
    #1 check_model();
    chk("dbl_alu_a", 32'(ex_alu_a), 32'h00AA);
    chk("dbl_fwd_a", 32'(ex_fwd_a), 32'h1);
    exmem_reg_write = 0;
    #1 check_model();
    chk("mw_alu_a", 32'(ex_alu_a), 32'h00BB);
    chk("mw_fwd_a", 32'(ex_fwd_a), 32'h2);
    tick();

    // MEM/WB producer seen only in the first of three stall cycles.
    set_idle();
    load_instr(2'd0, 2'd2, 2'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd3, 6'h3F, 1'b1);
    tick();
    set_idle();
    stall = 1;
    memwb_reg_write = 1; memwb_rd = 2'd2; memwb_value = 16'h1234;
    #1 check_model();
    chk("stall1_alu_b", 32'(ex_alu_b), 32'h1234);
    tick();
    memwb_reg_write = 0;
    #1 check_model();
    chk("stall2_alu_b", 32'(ex_alu_b), 32'h1234);
    chk("stall2_fwd_b", 32'(ex_fwd_b), 32'h0);
    tick();
    #1 check_model();
    chk("stall3_alu_b", 32'(ex_alu_b), 32'h1234);
    tick();
    stall = 0;
    #1 check_model();
    chk("post_stall_alu_b", 32'(ex_alu_b), 32'h1234);
    tick();

    // Flush and stall on the same edge.
    set_idle();
    load_instr(2'd1, 2'd1, 2'd1, 16'h0001, 16'h0001, 16'h0000, 1'b0, 4'd1, 6'd1, 1'b1);
    stall = 1; flush = 1;
    tick();
    set_idle();
    #1 check_model();
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_reg_write", 32'(ex_reg_write), 32'h0);
    chk("flush_br_op", 32'(ex_br_op), 32'h3F);
    tick();

    // Immediate selected for alu B while branch B still sees forwarded rt.
    load_instr(2'd0, 2'd3, 2'd2, 16'h0000, 16'h0001, 16'hFFFE, 1'b1, 4'd0, 6'd0, 1'b1);
    tick();
    set_idle();
    exmem_reg_write = 1; exmem_rd = 2'd3; exmem_value = 16'h0007;
    #1 check_model();
    chk("imm_alu_b", 32'(ex_alu_b), 32'hFFFE);
    chk("imm_br_b", 32'(ex_br_b), 32'h0007);
    chk("imm_fwd_b", 32'(ex_fwd_b), 32'h1);
    tick();

    // Randomized traffic, with one reset landing in the middle of a stall.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      if (i == 200) begin
        stall = 1; flush = 0;
        #1 check_model();
        tick();
        do_reset();
        randomize_inputs();
        stall = 0; flush = 0; id_valid = 1;
      end
      #1 check_model();
      tick();
    end
    #1 check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
